fmul_pipe: RTL and testbench
============================

// Module: fmul_pipe
//
// PURPOSE
// - Pipelined, parametrised IEEE-754-style floating-point multiplier; successor to the combinational single-precision fmul.
// - Adds a 3-stage pipeline, valid/ready flow control, special-value handling (inf/NaN), overflow/underflow saturation and flags.
// - Sits between the FPU issue logic and the writeback arbiter; one product accepted per cycle when not stalled.
//
// PARAMETERS
// - EXP_W   8    exponent field width
// - MAN_W   23   stored mantissa width (hidden 1 implied)
// - BIAS    127  exponent bias; must equal 2**(EXP_W-1)-1
// - W       derived: 1+EXP_W+MAN_W (localparam, not overridable)
//
// PORTS
// - clk        in   1  rising-edge clock
// - rstn       in   1  asynchronous active-low reset
// - in_valid   in   1  operands valid
// - in_ready   out  1  block accepts operands this cycle
// - x1         in   W  operand A {sign, exp, man}
// - x2         in   W  operand B
// - out_valid  out  1  result valid
// - out_ready  in   1  consumer accepts result
// - y          out  W  product
// - ovf        out  1  result saturated to inf by exponent overflow (valid with out_valid)
// - unf        out  1  result flushed to zero by exponent underflow (valid with out_valid)
//
// BEHAVIOUR
// - Reset (async, rstn=0): all stage valid bits, out_valid, y, ovf, unf = 0. In-flight operations discarded; no output after release until new inputs.
// - Flow: adv = !out_valid | out_ready; in_ready = adv (combinational). All three stages shift together on adv; nothing moves when !adv. Bubbles are not collapsed.
// - Accept on in_valid & in_ready. Latency 3 cycles accept->out_valid when out_ready held 1; throughput 1/cycle.
// - While out_valid & !out_ready: y, ovf, unf held stable.
// - S1: unpack; sy = s1^s2; classify each operand: zero (exp=0, any man -> denormals flushed), inf (exp all-ones, man=0), NaN (exp all-ones, man!=0); ea = e1+e2-BIAS in signed EXP_W+2 bits.
// - S2: full product P = {1,m1}*{1,m2}, 2*(MAN_W+1) bits.
// - S3: normalise: if P MSB set, mantissa = P[top-1 -: MAN_W], e = ea+1; else P[top-2 -: MAN_W], e = ea. Rounding per CONFIGURATION; rounding carry-out sets mantissa 0 and e+1.
// - Special priority (highest first):
//   1 NaN input, or inf*zero -> y = {0, all-ones, 1, zeros} (canonical qNaN), flags 0.
//   2 inf input -> {sy, all-ones, 0}, flags 0.
//   3 zero input -> {sy, 0, 0}, flags 0.
//   4 e >= 2**EXP_W-1 -> {sy, all-ones, 0}, ovf=1.
//   5 e <= 0 -> {sy, 0, 0}, unf=1 (no denormal output).
//   6 else {sy, e[EXP_W-1:0], mantissa}.
// - Overflow check applies after rounding carry.
//
// CONFIGURATION
// - FMUL_PIPE_RNE_EN defined: round-to-nearest-even using guard bit + sticky (OR of all lower product bits); tie rounds to even LSB.
// - Not defined: truncation (round toward zero), bit-identical mantissa to legacy fmul for normal in-range results.
//
// TESTING
// - 0x40000000 * 0x40400000, out_ready=1 -> y=0x40C00000 exactly 3 cycles after accept, ovf=unf=0.
// - 0x3FC00000 * 0x3FC00000 (normalise path) -> y=0x40100000; 0x00000000 * 0xC0000000 -> y=0x80000000.
// - 0x7F000000 * 0x7F000000 -> y=0x7F800000, ovf=1; 0x00800000 * 0x00800000 -> y=0x00000000, unf=1.
// - 0x7F800000 * 0x00000000 -> y=0x7FC00000; 0xFF800000 * 0x40000000 -> y=0xFF800000.
// - 0x3F800001 * 0x3FC00000 -> y=0x3FC00001 without FMUL_PIPE_RNE_EN, 0x3FC00002 with it.
// - Backpressure: stream 5 ops, hold out_ready=0 4 cycles -> in_ready=0 once out_valid, y stable, no ops lost/duplicated, order kept; assert rstn=0 mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/fmul_pipe.sv
// fmul_pipe: three-stage pipelined floating-point multiplier with valid/ready
// flow control, inf/NaN handling, and overflow/underflow saturation with flags.
// Stages: S1 unpack/classify/exponent sum, S2 mantissa product,
// S3 normalise/round/special-case select into the output register.
// Optional feature macro: FMUL_PIPE_RNE_EN (round-to-nearest-even); when it
// is not defined the mantissa is truncated (round toward zero).
// Denormal inputs are treated as zero, and no denormal results are produced.
module fmul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         ovf,
    output logic         unf
);

    // Two guard bits above the exponent field let the sum, the normalise
    // increment and the rounding carry all be held without wrapping.
    localparam int EA_W = EXP_W + 2;
    localparam int PW   = 2 * (MAN_W + 1);
    localparam logic signed [EA_W-1:0] E_MAX = EA_W'(2**EXP_W - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Every stage shifts together; a stalled output freezes the whole pipe.
    logic adv;
    logic out_valid_q;
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // ---------------- S1: unpack and classify ----------------
    logic [EXP_W-1:0] ea_in, eb_in;
    logic [MAN_W-1:0] ma_in, mb_in;
    logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic             sy1_d, nan1_d, inf1_d, zero1_d;
    logic [EA_W-1:0]  ea1_d;

    assign ea_in  = x1[W-2 -: EXP_W];
    assign eb_in  = x2[W-2 -: EXP_W];
    assign ma_in  = x1[MAN_W-1:0];
    assign mb_in  = x2[MAN_W-1:0];
    assign zero_a = (ea_in == '0);
    assign zero_b = (eb_in == '0);
    assign inf_a  = (ea_in == '1) && (ma_in == '0);
    assign inf_b  = (eb_in == '1) && (mb_in == '0);
    assign nan_a  = (ea_in == '1) && (ma_in != '0);
    assign nan_b  = (eb_in == '1) && (mb_in != '0);

    // inf*zero has no meaningful value, so it is folded into the NaN class.
    assign sy1_d   = x1[W-1] ^ x2[W-1];
    assign nan1_d  = nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a);
    assign inf1_d  = inf_a || inf_b;
    assign zero1_d = zero_a || zero_b;
    assign ea1_d   = EA_W'(ea_in) + EA_W'(eb_in) - EA_W'(BIAS);

    logic             v1_q, sy1_q, nan1_q, inf1_q, zero1_q;
    logic [EA_W-1:0]  ea1_q;
    logic [MAN_W-1:0] ma1_q, mb1_q;

    // S1 register: capture classified operands when the pipe advances.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q    <= 1'b0;
            sy1_q   <= 1'b0;
            nan1_q  <= 1'b0;
            inf1_q  <= 1'b0;
            zero1_q <= 1'b0;
            ea1_q   <= '0;
            ma1_q   <= '0;
            mb1_q   <= '0;
        end else if (adv) begin
            v1_q    <= in_valid;
            sy1_q   <= sy1_d;
            nan1_q  <= nan1_d;
            inf1_q  <= inf1_d;
            zero1_q <= zero1_d;
            ea1_q   <= ea1_d;
            ma1_q   <= ma_in;
            mb1_q   <= mb_in;
        end
    end

    // ---------------- S2: full mantissa product ----------------
    logic [PW-1:0] op_a, op_b, p2_d;
    assign op_a = PW'({1'b1, ma1_q});
    assign op_b = PW'({1'b1, mb1_q});
    assign p2_d = op_a * op_b;

    logic            v2_q, sy2_q, nan2_q, inf2_q, zero2_q;
    logic [EA_W-1:0] ea2_q;
    logic [PW-1:0]   p2_q;

    // S2 register: hold the product alongside the forwarded class bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2_q    <= 1'b0;
            sy2_q   <= 1'b0;
            nan2_q  <= 1'b0;
            inf2_q  <= 1'b0;
            zero2_q <= 1'b0;
            ea2_q   <= '0;
            p2_q    <= '0;
        end else if (adv) begin
            v2_q    <= v1_q;
            sy2_q   <= sy1_q;
            nan2_q  <= nan1_q;
            inf2_q  <= inf1_q;
            zero2_q <= zero1_q;
            ea2_q   <= ea1_q;
            p2_q    <= p2_d;
        end
    end

    // ---------------- S3: normalise, round, select ----------------
    logic                   hi;
    logic [MAN_W-1:0]       man_n, man_r;
    logic                   carry;
    logic signed [EA_W-1:0] e_n, e_r;
    logic [W-1:0]           y_d;
    logic                   ovf_d, unf_d;
`ifdef FMUL_PIPE_RNE_EN
    logic                   guard, sticky, round_up;
`else
    // Truncation never looks below the kept mantissa bits.
    logic                   unused_low_bits;
    assign unused_low_bits = ^p2_q[PW-3-MAN_W:0];
`endif

    // Normalise the product, apply rounding, then resolve special cases.
    always_comb begin
        hi    = p2_q[PW-1];
        man_n = hi ? p2_q[PW-2 -: MAN_W] : p2_q[PW-3 -: MAN_W];
        e_n   = hi ? (ea2_q + EA_W'(1)) : ea2_q;
`ifdef FMUL_PIPE_RNE_EN
        guard    = hi ? p2_q[PW-2-MAN_W] : p2_q[PW-3-MAN_W];
        sticky   = hi ? (|p2_q[PW-3-MAN_W:0]) : (|p2_q[PW-4-MAN_W:0]);
        round_up = guard && (sticky || man_n[0]);
        {carry, man_r} = {1'b0, man_n} + (MAN_W+1)'(round_up);
`else
        carry = 1'b0;
        man_r = man_n;
`endif
        // A rounding carry leaves man_r at zero and bumps the exponent; the
        // overflow test below therefore sees the post-rounding exponent.
        e_r   = e_n + EA_W'(carry);

        y_d   = {sy2_q, e_r[EXP_W-1:0], man_r};
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (nan2_q) begin
            y_d = QNAN;
        end else if (inf2_q) begin
            y_d = {sy2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero2_q) begin
            y_d = {sy2_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
        end else if (e_r >= E_MAX) begin
            y_d   = {sy2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_d = 1'b1;
        end else if (e_r[EA_W-1] || (e_r == '0)) begin
            y_d   = {sy2_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            unf_d = 1'b1;
        end
    end

    logic [W-1:0] y_q;
    logic         ovf_q, unf_q;

    // Output register: loads on advance, so it holds steady while stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= v2_q;
            y_q         <= y_d;
            ovf_q       <= v2_q && ovf_d;
            unf_q       <= v2_q && unf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: table-driven, scoreboarded bench for fmul_pipe (single precision).
// Expected results are pushed when an operand pair is accepted and popped when
// the DUT hands a result over; hand-written sequences cover backpressure and
// an asynchronous reset in mid-stream.
module tb_fmul_pipe;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x1 = '0;
    logic [31:0] x2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] y;
    logic        ovf;
    logic        unf;

    fmul_pipe dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        ovf;
        logic        unf;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        ovf;
        logic        unf;
        int          acc;
        bit          lat;
    } sb_t;

    localparam int NV = 19;
    vec_t vecs [NV];
    vec_t idle;
    sb_t  sb [$];

    int   errors = 0;
    int   checks = 0;
    bit   hold_pend = 1'b0;
    logic [33:0] hold_val;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // One clock cycle: drive on the falling edge, then observe the handshake.
    task automatic cycle(input bit iv, input vec_t v, input bit ordy, input bit lat, output bit acc);
        sb_t e;
        @(negedge clk);
        in_valid  = iv;
        x1        = v.a;
        x2        = v.b;
        out_ready = ordy;
        #1;
        if (hold_pend && out_valid)
            check_eq("hold_stable", {30'b0, ovf, unf, y}, {30'b0, hold_val});
        hold_pend = 1'b0;
        if (out_valid) begin
            if (!out_ready) begin
                check_eq("in_ready_stall", in_ready, 0);
                hold_pend = 1'b1;
                hold_val  = {ovf, unf, y};
            end else if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got y=%h, want no output", y);
            end else begin
                e = sb.pop_front();
                $display("txn %h * %h -> y=%h ovf=%b unf=%b (want %h %b %b)",
                         e.a, e.b, y, ovf, unf, e.y, e.ovf, e.unf);
                check_eq("product", {30'b0, ovf, unf, y}, {30'b0, e.ovf, e.unf, e.y});
                if (e.lat)
                    check_eq("latency", 64'(cyc - e.acc), 3);
            end
        end
        acc = iv && in_ready;
        if (acc) begin
            e.a = v.a; e.b = v.b; e.y = v.y; e.ovf = v.ovf; e.unf = v.unf;
            e.acc = cyc; e.lat = lat;
            sb.push_back(e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        int idx;

        idle = '{32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
        vecs[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0};
        vecs[1]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0};
        vecs[2]  = '{32'h00000000, 32'hC0000000, 32'h80000000, 1'b0, 1'b0};
        vecs[3]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0};
        vecs[4]  = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1};
        vecs[5]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0};
        vecs[6]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0};
`ifdef FMUL_PIPE_RNE_EN
        vecs[7]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b0, 1'b0};
`else
        vecs[7]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00001, 1'b0, 1'b0};
`endif
        vecs[8]  = '{32'h7FC12345, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0};
        vecs[9]  = '{32'h80000000, 32'h7F800000, 32'h7FC00000, 1'b0, 1'b0};
        vecs[10] = '{32'h00000001, 32'h40000000, 32'h00000000, 1'b0, 1'b0};
        vecs[11] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0};
        vecs[12] = '{32'h7E800000, 32'h40000000, 32'h7F000000, 1'b0, 1'b0};
        vecs[13] = '{32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 1'b0};
        vecs[14] = '{32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1};
        vecs[15] = '{32'hBFC00000, 32'h3FC00000, 32'hC0100000, 1'b0, 1'b0};
        vecs[16] = '{32'hC0400000, 32'h40800000, 32'hC1400000, 1'b0, 1'b0};
        vecs[17] = '{32'hFF800000, 32'hFF800000, 32'h7F800000, 1'b0, 1'b0};
        vecs[18] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 1'b0, 1'b0};

        // Reset state.
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_y", y, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_unf", unf, 0);
        check_eq("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rstn = 1'b1;

        // Single operation, then idle: latency of exactly 3 cycles.
        cycle(1'b1, vecs[0], 1'b1, 1'b1, acc);
        for (int i = 0; i < 6; i++) cycle(1'b0, idle, 1'b1, 1'b1, acc);
        check_eq("single_drain", sb.size(), 0);

        // Whole table streamed back to back with out_ready held high.
        idx = 0;
        for (int c = 0; c < 200 && (idx < NV || sb.size() > 0); c++) begin
            cycle(idx < NV, vecs[idx < NV ? idx : 0], 1'b1, 1'b1, acc);
            if (acc) idx++;
        end
        check_eq("table_accepted", idx, NV);
        check_eq("table_drain", sb.size(), 0);

        // Backpressure: 5 ops, out_ready low for 4 cycles once results appear.
        idx = 0;
        for (int c = 0; c < 60 && (idx < 5 || sb.size() > 0); c++) begin
            cycle(idx < 5, vecs[idx < 5 ? idx : 0], !(c >= 3 && c < 7), 1'b0, acc);
            if (acc) idx++;
        end
        check_eq("bp_accepted", idx, 5);
        check_eq("bp_drain", sb.size(), 0);

        // Asynchronous reset in mid-stream.
        for (int c = 0; c < 4; c++) cycle(1'b1, vecs[c + 5], 1'b1, 1'b1, acc);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_eq("pre_reset_valid", out_valid, 1);
        rstn = 1'b0;
        #1;
        check_eq("async_rst_valid", out_valid, 0);
        check_eq("async_rst_y", y, 0);
        check_eq("async_rst_flags", {ovf, unf}, 0);
        sb.delete();
        hold_pend = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, idle, 1'b1, 1'b1, acc);
            check_eq("post_reset_idle", out_valid, 0);
        end

        // Recovery after reset.
        cycle(1'b1, vecs[16], 1'b1, 1'b1, acc);
        for (int i = 0; i < 6; i++) cycle(1'b0, idle, 1'b1, 1'b1, acc);
        check_eq("recover_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
